prga: RTL and testbench



---
 rtl/prga.sv | 144 ++++++++++++++
 tb/tb_prga.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prga.sv
// prga: ARC4 pseudo-random generation and decryption stage.
// Walks the permuted S array left by key scheduling, swaps S[i]/S[j] in
// place, and writes a length-prefixed plaintext (ct[k] ^ keystream) to PT.
//
// Handshake: rdy=1 means idle. A run starts on the rising edge where
// en=1 and rdy=1; rdy drops from the next cycle and returns high once the
// last plaintext byte has been written. en is ignored while rdy=0.
//
// Every memory output is a register. Values assigned in a state appear on
// the ports in the following cycle. The memory returns read data one cycle
// after it sees the address.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN, ST_LEN_W, ST_LEN_R,
    ST_I, ST_I_W, ST_I_R, ST_J_W, ST_J_R,
    ST_WI, ST_P, ST_P_W, ST_P_R, ST_DONE
  } state_t;

  state_t     state;
  logic [7:0] i, j, k, n, si, sj, ctk, pad;

  // PT memory is write-only from this block's point of view.
  logic unused_pt_rddata;
  assign unused_pt_rddata = ^pt_rddata;

  // The plaintext byte being written is held in pad.
  assign pt_wrdata = pad;

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rdy      <= 1'b1;
      s_addr   <= 8'd0;
      s_wrdata <= 8'd0;
      s_wren   <= 1'b0;
      ct_addr  <= 8'd0;
      pt_addr  <= 8'd0;
      pt_wren  <= 1'b0;
      i        <= 8'd0;
      j        <= 8'd0;
      k        <= 8'd0;
      n        <= 8'd0;
      si       <= 8'd0;
      sj       <= 8'd0;
      ctk      <= 8'd0;
      pad      <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_wren  <= 1'b0;
          pt_wren <= 1'b0;
          if (en) begin
            state   <= ST_LEN;
            rdy     <= 1'b0;
            i       <= 8'd0;
            j       <= 8'd0;
            k       <= 8'd0;
            ct_addr <= 8'd0;
          end
        end
        ST_LEN:   state <= ST_LEN_W;
        ST_LEN_W: state <= ST_LEN_R;
        ST_LEN_R: begin
          // Length byte is copied straight through to pt[0].
          n       <= ct_rddata;
          pt_addr <= 8'd0;
          pad     <= ct_rddata;
          pt_wren <= 1'b1;
          state   <= (ct_rddata == 8'd0) ? ST_DONE : ST_I;
        end
        ST_I: begin
          i       <= i + 8'd1;
          k       <= k + 8'd1;
          s_addr  <= i + 8'd1;
          ct_addr <= k + 8'd1;
          s_wren  <= 1'b0;
          pt_wren <= 1'b0;
          state   <= ST_I_W;
        end
        ST_I_W:   state <= ST_I_R;
        ST_I_R: begin
          si     <= s_rddata;
          ctk    <= ct_rddata;
          j      <= j + s_rddata;
          s_addr <= j + s_rddata;
          state  <= ST_J_W;
        end
        ST_J_W:   state <= ST_J_R;
        ST_J_R: begin
          // First half of the swap: S[j] <= S[i].
          sj       <= s_rddata;
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= ST_WI;
        end
        ST_WI: begin
          // Second half: S[i] <= old S[j]. With i==j both writes agree.
          s_addr   <= i;
          s_wrdata <= sj;
          s_wren   <= 1'b1;
          state    <= ST_P;
        end
        ST_P: begin
          s_wren <= 1'b0;
          s_addr <= si + sj;
          state  <= ST_P_W;
        end
        ST_P_W:   state <= ST_P_R;
        ST_P_R: begin
          pt_addr <= k;
          pad     <= s_rddata ^ ctk;
          pt_wren <= 1'b1;
          state   <= (k == n) ? ST_DONE : ST_I;
        end
        ST_DONE: begin
          s_wren  <= 1'b0;
          pt_wren <= 1'b0;
          rdy     <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prga.sv
// Bench for prga: behavioural memories, a software ARC4 model that
// predicts the ordered S and PT write streams plus final memory images,
// and directed message vectors with hand-computed results.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_rddata, pt_wrdata;
  logic       pt_wren;

  prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous single-port memories, read data one cycle after address
  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_wren)  s_mem[s_addr]   = s_wrdata;
    if (pt_wren) pt_mem[pt_addr] = pt_wrdata;
  end

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_s_q[$];
  logic [15:0] exp_pt_q[$];
  logic [7:0]  exp_pt [256];
  logic [7:0]  exp_s  [256];
  logic [15:0] e_s, e_pt;
  int s_wr_cnt = 0;
  int pt_wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // compare process: every write strobe must match the next predicted write
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_wren) begin
        s_wr_cnt++;
        if (exp_s_q.size() == 0) check("s_write_unexpected", {16'd0, s_addr, s_wrdata}, 32'h1_0000);
        else begin
          e_s = exp_s_q.pop_front();
          check("s_write", {16'd0, s_addr, s_wrdata}, {16'd0, e_s});
        end
      end
      if (pt_wren) begin
        pt_wr_cnt++;
        if (exp_pt_q.size() == 0) check("pt_write_unexpected", {16'd0, pt_addr, pt_wrdata}, 32'h1_0000);
        else begin
          e_pt = exp_pt_q.pop_front();
          check("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, e_pt});
        end
      end
    end
  end

  // software ARC4 keystream/decrypt over the current memory contents
  task automatic build_model();
    int sm [256];
    int n, i, j, t, pad;
    for (int x = 0; x < 256; x++) sm[x] = int'(s_mem[x]);
    n = int'(ct_mem[0]);
    exp_pt[0] = 8'(n);
    exp_pt_q.push_back({8'd0, 8'(n)});
    i = 0;
    j = 0;
    for (int kk = 1; kk <= n; kk++) begin
      i = (i + 1) & 255;
      j = (j + sm[i]) & 255;
      exp_s_q.push_back({8'(j), 8'(sm[i])});
      exp_s_q.push_back({8'(i), 8'(sm[j])});
      t = sm[i]; sm[i] = sm[j]; sm[j] = t;
      pad = sm[(sm[i] + sm[j]) & 255];
      exp_pt[kk] = 8'(pad) ^ ct_mem[kk];
      exp_pt_q.push_back({8'(kk), exp_pt[kk]});
    end
    for (int x = 0; x < 256; x++) exp_s[x] = 8'(sm[x]);
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
  endtask

  task automatic clear_mems();
    for (int x = 0; x < 256; x++) begin
      ct_mem[x] = 8'h00;
      pt_mem[x] = 8'hEE;
    end
  endtask

  // driver: one start pulse, wait for rdy with a cycle budget, then check
  task automatic do_run(output int cyc);
    int n_len;
    build_model();
    n_len = int'(ct_mem[0]);
    s_wr_cnt = 0;
    pt_wr_cnt = 0;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check("rdy_low_after_start", {31'd0, rdy}, 32'd0);
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 4 + 9 * n_len + 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rdy_returned", {31'd0, rdy}, 32'd1);
    check("latency", cyc, 4 + 9 * n_len);
    check("s_write_count", s_wr_cnt, 2 * n_len);
    check("pt_write_count", pt_wr_cnt, n_len + 1);
    check("s_queue_drained", exp_s_q.size(), 0);
    check("pt_queue_drained", exp_pt_q.size(), 0);
    for (int x = 0; x <= n_len; x++) check($sformatf("pt_mem[%0d]", x), {24'd0, pt_mem[x]}, {24'd0, exp_pt[x]});
    for (int x = 0; x < 256; x++) check($sformatf("s_mem[%0d]", x), {24'd0, s_mem[x]}, {24'd0, exp_s[x]});
    exp_s_q.delete();
    exp_pt_q.delete();
  endtask

  initial begin
    int cyc;
    int kj, kt;
    clear_mems();
    set_identity();

    // reset values
    repeat (2) @(negedge clk);
    check("reset_rdy", {31'd0, rdy}, 32'd1);
    check("reset_s_wren", {31'd0, s_wren}, 32'd0);
    check("reset_pt_wren", {31'd0, pt_wren}, 32'd0);
    check("reset_addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
    check("reset_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity S, one-byte message
    clear_mems(); set_identity();
    ct_mem[0] = 8'h01; ct_mem[1] = 8'h00;
    do_run(cyc);
    check("t1_pt0", {24'd0, pt_mem[0]}, 32'h01);
    check("t1_pt1", {24'd0, pt_mem[1]}, 32'h02);
    check("t1_s1", {24'd0, s_mem[1]}, 32'h01);
    check("t1_latency", cyc, 13);

    // identity S, two-byte message with a real swap
    clear_mems(); set_identity();
    ct_mem[0] = 8'h02;
    do_run(cyc);
    check("t2_pt0", {24'd0, pt_mem[0]}, 32'h02);
    check("t2_pt1", {24'd0, pt_mem[1]}, 32'h02);
    check("t2_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("t2_s2", {24'd0, s_mem[2]}, 32'h03);
    check("t2_s3", {24'd0, s_mem[3]}, 32'h02);

    // j wraps to 0xFF, pad index wraps to 0
    clear_mems(); set_identity();
    s_mem[1] = 8'hFF; s_mem[8'hFF] = 8'h01;
    ct_mem[0] = 8'h01; ct_mem[1] = 8'hA5;
    do_run(cyc);
    check("t3_pt1", {24'd0, pt_mem[1]}, 32'hA5);
    check("t3_s1", {24'd0, s_mem[1]}, 32'h01);
    check("t3_sff", {24'd0, s_mem[8'hFF]}, 32'hFF);

    // empty message
    clear_mems(); set_identity();
    do_run(cyc);
    check("t4_pt0", {24'd0, pt_mem[0]}, 32'h00);
    check("t4_latency", cyc, 4);
    check("t4_no_s_writes", s_wr_cnt, 0);

    // full length, S from key scheduling with an all-zero 3-byte key
    clear_mems(); set_identity();
    kj = 0;
    for (int x = 0; x < 256; x++) begin
      kj = (kj + int'(s_mem[x])) & 255;
      kt = int'(s_mem[x]); s_mem[x] = s_mem[kj]; s_mem[kj] = 8'(kt);
    end
    ct_mem[0] = 8'hFF;
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'((x * 37 + 11) & 255);
    do_run(cyc);
    check("t5_latency", cyc, 2299);

    // reset during J_R (eighth cycle after start), then a clean run
    clear_mems(); set_identity();
    ct_mem[0] = 8'h03; ct_mem[1] = 8'h10; ct_mem[2] = 8'h20; ct_mem[3] = 8'h30;
    build_model();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", {31'd0, rdy}, 32'd1);
    check("rst_mid_wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("rst_mid_s_addr", {24'd0, s_addr}, 32'd0);
    exp_s_q.delete();
    exp_pt_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_pt0_kept", {24'd0, pt_mem[0]}, 32'h03);
    do_run(cyc);
    check("t6_latency", cyc, 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
